// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: holds the PLL in reset, waits for a debounced lock and releases the core reset.
// Define PLL_RST_SEQ_LOSS_CNT_EN to build the saturating lock-loss counter on loss_cnt.
module pll_rst_seq #(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 65535,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned MAX_RETRIES    = 7
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       locked,
    input  logic       soft_rst,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [2:0] state,
    output logic [7:0] loss_cnt
);

    typedef enum logic [2:0] {
        PLL_RESET = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    localparam logic [15:0] RST_LAST    = 16'(PLL_RST_CYCLES - 1);
    localparam logic [15:0] LOCK_LAST   = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
    localparam logic [3:0]  RETRY_MAX   = 4'(MAX_RETRIES);

    state_t      st_q, st_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  retry_q, retry_d;
    logic [1:0]  sync_q;
    logic        locked_s;

    assign locked_s = sync_q[1];

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            st_q    <= PLL_RESET;
            cnt_q   <= '0;
            retry_q <= '0;
            sync_q  <= '0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            sync_q  <= {sync_q[0], locked};
        end
    end

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q + 16'd1;
        retry_d = retry_q;
        if (soft_rst) begin
            st_d    = PLL_RESET;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (st_q)
                PLL_RESET: begin
                    if (cnt_q == RST_LAST) begin
                        st_d  = WAIT_LOCK;
                        cnt_d = '0;
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        st_d  = STABLE;
                        cnt_d = '0;
                    end else if (cnt_q == LOCK_LAST) begin
                        cnt_d = '0;
                        if (retry_q == RETRY_MAX) begin
                            st_d = FAIL;
                        end else begin
                            st_d    = PLL_RESET;
                            retry_d = retry_q + 4'd1;
                        end
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        st_d  = WAIT_LOCK;
                        cnt_d = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        // retry_cnt is cleared on entry so it already reads 0 in the first RUN cycle
                        st_d    = RUN;
                        cnt_d   = '0;
                        retry_d = '0;
                    end
                end
                RUN: begin
                    cnt_d   = '0;
                    retry_d = '0;
                    if (!locked_s) begin
                        st_d = PLL_RESET;
                    end
                end
                FAIL: begin
                    cnt_d = '0;
                end
                default: begin
                    st_d  = PLL_RESET;
                    cnt_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        pll_rst   = (st_q == PLL_RESET) || (st_q == FAIL);
        sys_rst_n = (st_q == RUN);
        fail      = (st_q == FAIL);
        retry_cnt = retry_q;
        state     = st_q;
    end

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    logic [7:0] loss_q;
    logic       loss_evt;

    // soft_rst wins over a simultaneous lock loss, so that exit is not counted
    assign loss_evt = (st_q == RUN) && !locked_s && !soft_rst;

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            loss_q <= '0;
        end else if (loss_evt && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign loss_cnt = loss_q;
`else
    assign loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_rst_seq.sv
// Self-checking bench for pll_rst_seq: directed scenarios plus random lock/reset stimulus
// compared every cycle against a phase/deadline reference model.
module tb_pll_rst_seq;

    localparam int unsigned PRC = 4;
    localparam int unsigned LT  = 100;
    localparam int unsigned SC  = 8;
    localparam int unsigned MR  = 2;

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    localparam int P_RST = 0, P_WAIT = 1, P_STAB = 2, P_RUN = 3, P_FAIL = 4;

    logic       refclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       locked = 1'b0;
    logic       soft_rst = 1'b0;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [2:0] state;
    logic [7:0] loss_cnt;

    always #10 refclk = ~refclk;

    pll_rst_seq #(
        .PLL_RST_CYCLES(PRC),
        .LOCK_TIMEOUT(LT),
        .STABLE_CYCLES(SC),
        .MAX_RETRIES(MR)
    ) dut (
        .refclk(refclk),
        .rst_n(rst_n),
        .locked(locked),
        .soft_rst(soft_rst),
        .pll_rst(pll_rst),
        .sys_rst_n(sys_rst_n),
        .fail(fail),
        .retry_cnt(retry_cnt),
        .state(state),
        .loss_cnt(loss_cnt)
    );

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase, cycles left in the phase, attempts used, loss events.
    int         m_phase = P_RST;
    int         m_left  = PRC;
    int         m_tries = 0;
    int         m_loss  = 0;
    logic [1:0] m_hist  = '0;

    task automatic model_edge();
        logic ls;
        ls = m_hist[1];
        if (!rst_n) begin
            m_phase = P_RST; m_left = PRC; m_tries = 0; m_loss = 0; m_hist = '0;
            return;
        end
        m_hist = {m_hist[0], locked};
        if (soft_rst) begin
            m_phase = P_RST; m_left = PRC; m_tries = 0;
            return;
        end
        case (m_phase)
            P_RST: begin
                if (m_left == 1) begin m_phase = P_WAIT; m_left = LT; end
                else m_left--;
            end
            P_WAIT: begin
                if (ls) begin m_phase = P_STAB; m_left = SC; end
                else if (m_left == 1) begin
                    if (m_tries == MR) m_phase = P_FAIL;
                    else begin m_tries++; m_phase = P_RST; m_left = PRC; end
                end else m_left--;
            end
            P_STAB: begin
                if (!ls) begin m_phase = P_WAIT; m_left = LT; end
                else if (m_left == 1) begin m_phase = P_RUN; m_tries = 0; end
                else m_left--;
            end
            P_RUN: begin
                m_tries = 0;
                if (!ls) begin
                    m_phase = P_RST; m_left = PRC;
                    if (LOSS_EN && m_loss < 255) m_loss++;
                end
            end
            default: ;
        endcase
    endtask

    function automatic int loss_exp(input int n);
        if (!LOSS_EN) return 0;
        return (n > 255) ? 255 : n;
    endfunction

    task automatic step();
        logic [17:0] got, exp;
        @(posedge refclk);
        model_edge();
        @(negedge refclk);
        got = {state, pll_rst, sys_rst_n, fail, retry_cnt, loss_cnt};
        exp = {3'(m_phase), (m_phase == P_RST) || (m_phase == P_FAIL), m_phase == P_RUN,
               m_phase == P_FAIL, 4'(m_tries), 8'(m_loss)};
        check("cyc", {14'd0, got}, {14'd0, exp});
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int bound);
        int n = 0;
        while (state !== s && n < bound) begin step(); n++; end
        if (state !== s) check(tag, {29'd0, state}, {29'd0, s});
    endtask

    task automatic count_in_state(input logic [2:0] s, input int bound, output int n);
        n = 0;
        while (state === s && n < bound) begin n++; step(); end
    endtask

    task automatic count_pll_hold(output int n);
        n = 0;
        do begin step(); n++; end while (pll_rst === 1'b1 && n < 20);
    endtask

    int n;

    initial begin
        // Reset values
        repeat (3) step();
        check("rst_state", state, 0);
        check("rst_pll", pll_rst, 1);
        check("rst_sys", sys_rst_n, 0);
        check("rst_fail", fail, 0);
        check("rst_retry", retry_cnt, 0);
        check("rst_loss", loss_cnt, 0);

        // Nominal bring-up
        rst_n = 1'b1;
        count_pll_hold(n);
        check("pll_hold", n, PRC);
        repeat (10) step();
        locked = 1'b1;
        n = 0;
        do begin step(); n++; end while (!sys_rst_n && n < 40);
        check("rel_lat", n, SC + 3);
        check("run_state", state, 3);
        repeat (2) step();
        check("run_retry", retry_cnt, 0);

        // Single-cycle lock loss, then saturation of the loss counter
        locked = 1'b0; step(); locked = 1'b1;
        n = 1;
        while (sys_rst_n && n < 10) begin step(); n++; end
        check("loss_lat", n, 3);
        check("loss_state", state, 0);
        check("loss_one", loss_cnt, loss_exp(1));
        for (int i = 2; i <= 300; i++) begin
            wait_state("relock", 3, 60);
            locked = 1'b0; step(); locked = 1'b1;
            step(); step();
        end
        check("loss_sat", loss_cnt, loss_exp(300));

        // Timeout windows to FAIL, then soft reset
        wait_state("run_pre_to", 3, 60);
        locked = 1'b0;
        for (int w = 0; w <= MR; w++) begin
            wait_state("to_wait", 1, 20);
            check("to_retry", retry_cnt, w);
            count_in_state(1, 200, n);
            check("to_len", n, LT);
        end
        check("fail_state", state, 4);
        check("fail_flag", fail, 1);
        check("fail_pll", pll_rst, 1);
        check("fail_sys", sys_rst_n, 0);
        repeat (5) step();
        check("fail_hold", state, 4);
        soft_rst = 1'b1; step(); soft_rst = 1'b0;
        check("soft_state", state, 0);
        check("soft_retry", retry_cnt, 0);
        check("soft_fail", fail, 0);

        // Lock glitch during STABLE restarts the timeout window
        wait_state("gl_wait", 1, 20);
        locked = 1'b1;
        repeat (5) step();
        check("gl_stable", state, 2);
        locked = 1'b0;
        wait_state("gl_back", 1, 10);
        check("gl_sys", sys_rst_n, 0);
        count_in_state(1, 200, n);
        check("gl_len", n, LT);

        // soft_rst coincident with the final timeout
        wait_state("pr_w1", 1, 20);
        check("pr_retry1", retry_cnt, 1);
        count_in_state(1, 200, n);
        wait_state("pr_w2", 1, 20);
        check("pr_retry2", retry_cnt, 2);
        repeat (LT - 1) step();
        soft_rst = 1'b1; step(); soft_rst = 1'b0;
        check("pr_state", state, 0);
        check("pr_fail", fail, 0);
        check("pr_retry", retry_cnt, 0);

        // Reset asserted during STABLE
        wait_state("mr_wait", 1, 20);
        count_in_state(1, 200, n);
        locked = 1'b1;
        wait_state("mr_stable", 2, 40);
        check("mr_pre_retry", retry_cnt, 1);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        check("mr_state", state, 0);
        check("mr_pll", pll_rst, 1);
        check("mr_sys", sys_rst_n, 0);
        check("mr_fail", fail, 0);
        check("mr_retry", retry_cnt, 0);
        check("mr_loss", loss_cnt, 0);
        count_pll_hold(n);
        check("mr_hold", n, PRC);

        // Random lock behaviour with occasional soft and hard resets
        for (int seg = 0; seg < 40; seg++) begin
            int len;
            logic lv;
            len = $urandom_range(1, 150);
            lv  = ($urandom_range(0, 2) != 0);
            for (int c = 0; c < len; c++) begin
                locked   = lv ^ ($urandom_range(0, 59) == 0);
                soft_rst = ($urandom_range(0, 299) == 0);
                rst_n    = ($urandom_range(0, 499) != 0);
                step();
            end
        end
        rst_n = 1'b1; soft_rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish (vectors %0d)", n_vec);
        $fatal(1);
    end

endmodule

// File: doc/pll_rst_seq.md
PLL_RST_SEQ -- requirements
Module: pll_rst_seq

Interface
REQ-001 Parameter PLL_RST_CYCLES, default 16, SHALL set the refclk cycles pll_rst is held high per attempt (1..65535).
REQ-002 Parameter LOCK_TIMEOUT, default 65535, SHALL set the refclk cycles allowed for lock per attempt (1..65535).
REQ-003 Parameter STABLE_CYCLES, default 1024, SHALL set the consecutive locked cycles required before release (1..65535).
REQ-004 Parameter MAX_RETRIES, default 7, SHALL set the retry attempts before FAIL (0..15).
REQ-005 Port refclk  input  1  SHALL be the free-running 50 MHz reference clock; all logic is on its rising edge.
REQ-006 Port rst_n  input  1  SHALL be the synchronous, active-low reset.
REQ-007 Port locked  input  1  SHALL be the PLL lock indication, asynchronous to refclk.
REQ-008 Port soft_rst  input  1  SHALL be a synchronous single-cycle request to restart sequencing.
REQ-009 Port pll_rst  output  1  SHALL be the active-high reset driven to the PLL.
REQ-010 Port sys_rst_n  output  1  SHALL be the active-low reset released to the downstream core.
REQ-011 Port fail  output  1  SHALL be high when all lock attempts are exhausted.
REQ-012 Port retry_cnt  output  4  SHALL be the number of timeouts in the current sequence.
REQ-013 Port state  output  3  SHALL expose the FSM state encoding: PLL_RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
REQ-014 Port loss_cnt  output  8  SHALL count lock-loss events in RUN (see Configuration).

Function
REQ-015 locked SHALL pass through a 2-flop synchronizer (locked_s); the FSM SHALL use only locked_s.
REQ-016 All outputs SHALL be decoded from registers only, with no combinational path from any input.
REQ-017 A single 16-bit counter cnt SHALL be cleared on every state transition.
REQ-018 PLL_RESET: pll_rst=1 and locked_s is ignored; when cnt==PLL_RST_CYCLES-1 -> WAIT_LOCK, else cnt++.
REQ-019 WAIT_LOCK: pll_rst=0; locked_s=1 -> STABLE; otherwise, when cnt==LOCK_TIMEOUT-1, go to FAIL if retry_cnt==MAX_RETRIES, else retry_cnt++ and go to PLL_RESET; otherwise cnt++.
REQ-020 STABLE: locked_s=0 -> WAIT_LOCK, with a fresh timeout; cnt==STABLE_CYCLES-1 -> RUN; else cnt++.
REQ-021 RUN: sys_rst_n=1 and retry_cnt is cleared to 0; locked_s=0 -> PLL_RESET.
REQ-022 sys_rst_n SHALL be 0 in every state other than RUN.
REQ-023 FAIL: pll_rst=1, sys_rst_n=0, fail=1; the FSM SHALL exit FAIL only via rst_n or soft_rst.
REQ-024 soft_rst=1 in any state SHALL force PLL_RESET with cnt=0 and retry_cnt=0, taking priority over all other transitions in the same cycle.
REQ-025 Release latency: with locked rising before edge 0 while in WAIT_LOCK, sys_rst_n SHALL rise after edge STABLE_CYCLES+2.

Reset
REQ-026 rst_n=0 sampled on an edge SHALL force state=PLL_RESET, cnt=0, retry_cnt=0, loss_cnt=0, and clear both synchronizer flops.
REQ-027 Under reset, outputs SHALL be: pll_rst=1, sys_rst_n=0, fail=0, state=0.
REQ-028 Reset asserted mid-sequence, in any state, SHALL restart from PLL_RESET with a full PLL_RST_CYCLES hold.

Configuration
REQ-029 With macro PLL_RST_SEQ_LOSS_CNT_EN defined, loss_cnt SHALL increment by 1 on each RUN->PLL_RESET transition caused by locked_s=0.
REQ-030 With PLL_RST_SEQ_LOSS_CNT_EN defined, loss_cnt SHALL saturate at 255 and be cleared only by rst_n.
REQ-031 Without PLL_RST_SEQ_LOSS_CNT_EN, loss_cnt SHALL be tied to 0 and no counter register SHALL be instantiated.

Verification
Bench parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=8, MAX_RETRIES=2.
REQ-032 Nominal: release rst_n, raise locked 10 cycles after pll_rst falls -> pll_rst high for 4 cycles after reset; sys_rst_n rises after edge 10 from locked rise; state=3.
REQ-033 Timeout/fail: locked held 0 -> three 100-cycle WAIT_LOCK windows with retry_cnt 0->1->2, then state=4, fail=1, pll_rst=1; a soft_rst pulse then gives state=0 and retry_cnt=0.
REQ-034 Glitch: locked high 5 cycles then low during STABLE -> state returns to 1, sys_rst_n stays 0, and a fresh 100-cycle timeout starts.
REQ-035 Lock loss: drop locked for 1 cycle in RUN -> sys_rst_n=0 within 3 edges, state=0, loss_cnt=1 with macro / 0 without; saturation at 255 after 300 losses.
REQ-036 Priority: soft_rst coincident with a timeout at retry_cnt=2 -> state=0, fail=0, retry_cnt=0.
REQ-037 Mid-run reset: assert rst_n=0 for 1 cycle in STABLE -> all outputs take reset values on the next edge, followed by a full 4-cycle pll_rst hold.
